// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: write-back request, register-write and scoreboard query signals of reg_wb_arbiter.
interface reg_wb_arbiter_if #(
  parameter int NUM_REQ      = 3,
  parameter int LEN_REG      = 32,
  parameter int LEN_REG_ADDR = 5
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*LEN_REG_ADDR-1:0] req_addr;
  logic [NUM_REQ*LEN_REG-1:0]      req_data;
  logic                            wb_flag;
  logic [LEN_REG_ADDR-1:0]         wb_addr;
  logic [LEN_REG-1:0]              wb_data;
  logic                            iss_valid;
  logic [LEN_REG_ADDR-1:0]         iss_addr;
  logic [LEN_REG_ADDR-1:0]         qry_rs1;
  logic [LEN_REG_ADDR-1:0]         qry_rs2;
  logic                            busy_rs1;
  logic                            busy_rs2;
  logic                            err_waw;
  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_addr, qry_rs1, qry_rs2,
    input  req_ready, wb_flag, wb_addr, wb_data, busy_rs1, busy_rs2, err_waw
  );
  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_addr, qry_rs1, qry_rs2,
    output req_ready, wb_flag, wb_addr, wb_data, busy_rs1, busy_rs2, err_waw
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: one-grant-per-cycle register write-back arbiter with busy scoreboard.
// Define WB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module reg_wb_arbiter #(
  parameter int LEN_REG      = 32,
  parameter int NUM_REG      = 32,
  parameter int LEN_REG_ADDR = 5,
  parameter int NUM_REQ      = 3
) (
  input logic clk,
  input logic rstn,
  reg_wb_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic                    found;
  logic [IW-1:0]           sel;
  logic [LEN_REG_ADDR-1:0] sel_addr;
  logic [LEN_REG-1:0]      sel_data;
  logic [NUM_REG-1:0]      busy, busy_nxt;
`ifdef WB_RR_EN
  logic [IW-1:0]           rr_ptr;
`endif
  always_comb begin
    int j;
    found = 1'b0;
    sel = '0;
    bus.req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_RR_EN
      j = (int'(rr_ptr) + 1 + k) % NUM_REQ;
`else
      j = k;
`endif
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        sel = IW'(j);
        bus.req_ready[j] = 1'b1;
      end
    end
  end
  assign sel_addr = bus.req_addr[int'(sel)*LEN_REG_ADDR +: LEN_REG_ADDR];
  assign sel_data = bus.req_data[int'(sel)*LEN_REG +: LEN_REG];
  // issue after write-back so a same-edge set overrides the clear
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_flag) busy_nxt[bus.wb_addr] = 1'b0;
    if (bus.iss_valid && bus.iss_addr != '0) busy_nxt[bus.iss_addr] = 1'b1;
  end
  assign bus.busy_rs1 = bus.qry_rs1 != '0 && busy[bus.qry_rs1];
  assign bus.busy_rs2 = bus.qry_rs2 != '0 && busy[bus.qry_rs2];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.wb_flag <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
      busy        <= '0;
      bus.err_waw <= 1'b0;
    end else begin
      bus.wb_flag <= found && sel_addr != '0;
      if (found && sel_addr != '0) begin
        bus.wb_addr <= sel_addr;
        bus.wb_data <= sel_data;
      end
      busy <= busy_nxt;
      if (bus.iss_valid && bus.iss_addr != '0 && busy[bus.iss_addr] &&
          !(bus.wb_flag && bus.wb_addr == bus.iss_addr))
        bus.err_waw <= 1'b1;
    end
  end
`ifdef WB_RR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_ptr <= IW'(NUM_REQ - 1);
    else if (found) rr_ptr <= sel;
  end
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: vector table for arbitration/write-back, hand sequences for scoreboard, WAW, r0, reset.
module tb_reg_wb_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  reg_wb_arbiter_if bus();
  reg_wb_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  exp_rr, exp_fp;
  } vec_t;
  typedef struct {
    logic        flag;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;
  vec_t vt[10];
  wb_t  sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req0(input logic [4:0] a, input logic [31:0] d);
    bus.req_valid = 3'b001;
    bus.req_addr  = {10'd0, a};
    bus.req_data  = {64'd0, d};
  endtask
  initial begin
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0; bus.qry_rs1 = '0; bus.qry_rs2 = '0;
    vt[0] = '{3'b111, 5'd10, 5'd11, 5'd12, 32'hA0A0_0000, 32'h1111_0001, 32'h2222_0002, 3'b001, 3'b001};
    vt[1] = '{3'b111, 5'd10, 5'd11, 5'd12, 32'hA0A0_0000, 32'h1111_0001, 32'h2222_0002, 3'b010, 3'b001};
    vt[2] = '{3'b111, 5'd10, 5'd11, 5'd12, 32'hA0A0_0000, 32'h1111_0001, 32'h2222_0002, 3'b100, 3'b001};
    vt[3] = '{3'b001, 5'd5,  5'd11, 5'd12, 32'hDEAD_BEEF, 32'h1111_0001, 32'h2222_0002, 3'b001, 3'b001};
    vt[4] = '{3'b000, 5'd5,  5'd11, 5'd12, 32'hDEAD_BEEF, 32'h1111_0001, 32'h2222_0002, 3'b000, 3'b000};
    vt[5] = '{3'b110, 5'd5,  5'd13, 5'd14, 32'h0, 32'h3333_0003, 32'h4444_0004, 3'b010, 3'b010};
    vt[6] = '{3'b101, 5'd15, 5'd13, 5'd14, 32'h5555_0005, 32'h3333_0003, 32'h4444_0004, 3'b100, 3'b001};
    vt[7] = '{3'b011, 5'd15, 5'd16, 5'd14, 32'h5555_0005, 32'h6666_0006, 32'h4444_0004, 3'b001, 3'b001};
    vt[8] = '{3'b110, 5'd15, 5'd16, 5'd17, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 3'b010, 3'b010};
    vt[9] = '{3'b100, 5'd15, 5'd16, 5'd0,  32'h5555_0005, 32'h6666_0006, 32'h8888_0008, 3'b100, 3'b100};
    #2 rstn = 1'b0;
    #1;
    chk("reset wb_flag", 32'(bus.wb_flag), 32'd0);
    chk("reset wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("reset wb_data", bus.wb_data, 32'd0);
    chk("reset err_waw", 32'(bus.err_waw), 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      wb_t e;
      logic [2:0] er;
      er = RR ? vt[i].exp_rr : vt[i].exp_fp;
      bus.req_valid = vt[i].valid;
      bus.req_addr  = {vt[i].a2, vt[i].a1, vt[i].a0};
      bus.req_data  = {vt[i].d2, vt[i].d1, vt[i].d0};
      #1;
      chk($sformatf("vec%0d req_ready", i), 32'(bus.req_ready), 32'(er));
      e.flag = 1'b0; e.addr = '0; e.data = '0;
      if (er[0]) begin e.addr = vt[i].a0; e.data = vt[i].d0; end
      if (er[1]) begin e.addr = vt[i].a1; e.data = vt[i].d1; end
      if (er[2]) begin e.addr = vt[i].a2; e.data = vt[i].d2; end
      e.flag = er != 3'b000 && e.addr != 5'd0;
      sb.push_back(e);
      step();
      bus.req_valid = '0;
      e = sb.pop_front();
      chk($sformatf("vec%0d wb_flag", i), 32'(bus.wb_flag), 32'(e.flag));
      if (e.flag) begin
        chk($sformatf("vec%0d wb_addr", i), 32'(bus.wb_addr), 32'(e.addr));
        chk($sformatf("vec%0d wb_data", i), bus.wb_data, e.data);
      end
    end
    // scoreboard set, clear one cycle after wb_flag, then set racing clear
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7; bus.qry_rs1 = 5'd7;
    step();
    bus.iss_valid = 1'b0;
    chk("sb set busy7", 32'(bus.busy_rs1), 32'd1);
    req0(5'd7, 32'h0000_0077);
    #1 chk("sb req ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    chk("sb wb_flag", 32'(bus.wb_flag), 32'd1);
    chk("sb no bypass", 32'(bus.busy_rs1), 32'd1);
    step();
    chk("sb cleared", 32'(bus.busy_rs1), 32'd0);
    bus.iss_valid = 1'b1;
    step();
    bus.iss_valid = 1'b0;
    chk("sb reissue", 32'(bus.busy_rs1), 32'd1);
    req0(5'd7, 32'h0000_0777);
    step();
    bus.req_valid = '0;
    bus.iss_valid = 1'b1;
    chk("race wb_flag", 32'(bus.wb_flag), 32'd1);
    step();
    bus.iss_valid = 1'b0;
    chk("race busy", 32'(bus.busy_rs1), 32'd1);
    chk("race err_waw", 32'(bus.err_waw), 32'd0);
    step();
    chk("race busy hold", 32'(bus.busy_rs1), 32'd1);
    // register 0
    req0(5'd0, 32'h1234_5678);
    #1 chk("r0 ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    chk("r0 wb_flag", 32'(bus.wb_flag), 32'd0);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0; bus.qry_rs2 = 5'd0;
    step();
    bus.iss_valid = 1'b0;
    chk("r0 busy", 32'(bus.busy_rs2), 32'd0);
    chk("r0 err_waw", 32'(bus.err_waw), 32'd0);
    // WAW on register 9
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9; bus.qry_rs1 = 5'd9; bus.qry_rs2 = 5'd7;
    step();
    chk("waw first", 32'(bus.err_waw), 32'd0);
    step();
    bus.iss_valid = 1'b0;
    chk("waw set", 32'(bus.err_waw), 32'd1);
    step();
    chk("waw sticky", 32'(bus.err_waw), 32'd1);
    chk("waw busy9", 32'(bus.busy_rs1), 32'd1);
    // async reset with a write in the output stage
    req0(5'd3, 32'hCAFE_F00D);
    step();
    bus.req_valid = '0;
    chk("pre-reset wb_flag", 32'(bus.wb_flag), 32'd1);
    chk("pre-reset wb_data", bus.wb_data, 32'hCAFE_F00D);
    rstn = 1'b0;
    #1;
    chk("async wb_flag", 32'(bus.wb_flag), 32'd0);
    chk("async wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("async wb_data", bus.wb_data, 32'd0);
    chk("async err_waw", 32'(bus.err_waw), 32'd0);
    chk("async busy9", 32'(bus.busy_rs1), 32'd0);
    chk("async busy7", 32'(bus.busy_rs2), 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
